// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the instruction
// fetch port and the load/store port. Each access runs IDLE -> ISSUE -> WAIT
// (MEM_LAT cycles) -> ACK, so back-to-back accesses take MEM_LAT+3 cycles.
// Build option: define ARB_RR_EN for round-robin tie-breaking between the two
// ports; when undefined the data port always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state;
  logic [3:0] count;
  logic       owner_d;    // 1: current access belongs to the data port
  logic       lat_we;     // latched store flag of the current access
  logic       pick_data;  // arbitration result for this cycle
  logic       unused;

`ifdef ARB_RR_EN
  logic       last_d;     // 1: most recent grant went to the data port
`endif

  // The wait counter is 4 bits wide, so latencies beyond 15 cannot be honoured.
  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
      $error("mem_arbiter: MEM_LAT must be within 1..15");
    end
  endgenerate

  // Byte-offset bits never reach the memory; word accesses only.
  assign unused = ^{if_addr[1:0], d_addr[1:0]};

  // Requesters hold their pipelines while a request is waiting for its ack.
  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Winner selection when the arbiter is idle.
  always_comb begin
    pick_data = d_req;
`ifdef ARB_RR_EN
    pick_data = d_req & (~if_req | ~last_d);
`endif
  end

  // Access sequencer: latches the winner, strobes memory once, waits, acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      owner_d   <= 1'b0;
      lat_we    <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_d <= pick_data;
            lat_we  <= pick_data & d_we;
            mem_we  <= pick_data & d_we;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            if (pick_data) begin
              mem_addr  <= d_addr[ADDR_W-1:2];
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= if_addr[ADDR_W-1:2];
            end
`ifdef ARB_RR_EN
            last_d  <= pick_data;
`endif
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          count <= LAT4;
          state <= WAIT;
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            if (!owner_d) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!lat_we) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter. A second
// instance with MEM_LAT=15 covers the long-latency case.
module tb_mem_arbiter;
  localparam int L   = 1;
  localparam int L15 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, busy, stall;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [29:0] mem_addr;

  logic        x_if_req, x_d_req, x_d_we;
  logic [31:0] x_if_addr, x_d_addr, x_d_wdata, x_mem_rdata;
  logic        x_if_ack, x_d_ack, x_mem_en, x_mem_we, x_busy, x_stall;
  logic [31:0] x_if_rdata, x_d_rdata, x_mem_wdata;
  logic [29:0] x_mem_addr;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .stall(stall)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L15)) dut15 (
    .clk(clk), .rst(rst), .if_req(x_if_req), .if_addr(x_if_addr), .if_ack(x_if_ack),
    .if_rdata(x_if_rdata), .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr),
    .d_wdata(x_d_wdata), .d_ack(x_d_ack), .d_rdata(x_d_rdata), .mem_en(x_mem_en),
    .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_rdata(x_mem_rdata), .busy(x_busy), .stall(x_stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Initial memory contents; word 4 holds an addi instruction.
  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 4) ? 32'h0050_0093 : {b, 8'h5A, ~b, 8'hC3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Memory macro model: read data valid only in the cycle MEM_LAT after mem_en.
  logic [31:0] rmem [256];
  logic        rinit = 1'b0;
  int          rcnt  = 0;
  logic [31:0] rdat  = '0;
  always @(negedge clk) begin
    if (!rinit) begin
      for (int i = 0; i < 256; i++) rmem[i] = pat(i);
      rinit = 1'b1;
    end
    if (rcnt > 0) rcnt--;
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) rmem[mem_addr[7:0]] = mem_wdata;
      else begin
        rcnt = L + 1;
        rdat = rmem[mem_addr[7:0]];
      end
    end
    mem_rdata = (rcnt == 1) ? rdat : 32'hBAD0_0BAD;
  end

  logic [31:0] rmem15 [256];
  logic        rinit15 = 1'b0;
  int          rcnt15  = 0;
  logic [31:0] rdat15  = '0;
  always @(negedge clk) begin
    if (!rinit15) begin
      for (int i = 0; i < 256; i++) rmem15[i] = pat(i);
      rinit15 = 1'b1;
    end
    if (rcnt15 > 0) rcnt15--;
    if (x_mem_en === 1'b1) begin
      if (x_mem_we === 1'b1) rmem15[x_mem_addr[7:0]] = x_mem_wdata;
      else begin
        rcnt15 = L15 + 1;
        rdat15 = rmem15[x_mem_addr[7:0]];
      end
    end
    x_mem_rdata = (rcnt15 == 1) ? rdat15 : 32'hBAD1_5BAD;
  end

  // Transaction-level reference: a grant in idle cycle g strobes memory in
  // g+1, acks in g+2+L, and the arbiter is free again from g+3+L.
  int          cyc, en_cyc, ack_cyc;
  logic        own_d, m_we, last_d;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rd, e_if_rd, e_d_rd;
  logic [31:0] ref_mem [256];

  task automatic tick();
    logic e_ia, e_da, gd;
    @(negedge clk);
    e_ia = (cyc == ack_cyc) && !own_d;
    e_da = (cyc == ack_cyc) && own_d;
    if (e_ia) e_if_rd = m_rd;
    if (e_da && !m_we) e_d_rd = m_rd;
    chk("if_ack", 32'(if_ack), 32'(e_ia));
    chk("d_ack", 32'(d_ack), 32'(e_da));
    chk("mem_en", 32'(mem_en), 32'(cyc == en_cyc));
    chk("busy", 32'(busy), 32'(cyc >= en_cyc && cyc <= ack_cyc));
    chk("stall", 32'(stall), 32'((if_req && !e_ia) || (d_req && !e_da)));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rdata", d_rdata, e_d_rd);
    if (cyc == en_cyc) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (rst) begin
      en_cyc = -100; ack_cyc = -100;
      e_if_rd = '0; e_d_rd = '0; last_d = 1'b0;
    end else if (cyc > ack_cyc && (if_req || d_req)) begin
`ifdef ARB_RR_EN
      gd = d_req && (!if_req || !last_d);
`else
      gd = d_req;
`endif
      last_d  = gd;
      own_d   = gd;
      m_we    = gd && d_we;
      m_addr  = gd ? d_addr[31:2] : if_addr[31:2];
      m_wdata = d_wdata;
      en_cyc  = cyc + 1;
      ack_cyc = cyc + 2 + L;
      if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      m_rd = ref_mem[m_addr[7:0]];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic af, ad;
    int   n, busy_n, guard;
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    x_if_req = 1'b0; x_d_req = 1'b0; x_d_we = 1'b0;
    x_if_addr = '0; x_d_addr = '0; x_d_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    cyc = 0; en_cyc = -100; ack_cyc = -100;
    own_d = 1'b0; m_we = 1'b0; last_d = 1'b0; m_addr = '0;
    m_wdata = '0; m_rd = '0; e_if_rd = '0; e_d_rd = '0;
    @(posedge clk);
    #1;

    // Reset state
    tick(); tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_x_busy", 32'(x_busy), 32'h0);
    rst = 1'b0;

    // Single fetch
    if_addr = 32'h0000_0010; if_req = 1'b1;
    tick();
    chk("fetch_en", 32'(mem_en), 32'h1);
    chk("fetch_addr", 32'(mem_addr), 32'h4);
    chk("fetch_we", 32'(mem_we), 32'h0);
    tick(); tick();
    chk("fetch_ack", 32'(if_ack), 32'h1);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    tick();

    // Store, then load back the stored word
    d_we = 1'b1; d_addr = 32'h0000_0008; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    tick();
    chk("st_en", 32'(mem_en), 32'h1);
    chk("st_we", 32'(mem_we), 32'h1);
    chk("st_addr", 32'(mem_addr), 32'h2);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); tick();
    chk("st_ack", 32'(d_ack), 32'h1);
    chk("st_rdata_held", d_rdata, 32'h0);
    d_we = 1'b0;
    tick();
    tick(); tick(); tick();
    chk("ld_ack", 32'(d_ack), 32'h1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();

    // Reset held two cycles in the middle of an access
    d_addr = 32'h0000_0040; d_req = 1'b1;
    tick(); tick();
    chk("rw_busy_before", 32'(busy), 32'h1);
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk("rw_d_ack", 32'(d_ack), 32'h0);
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_mem_en", 32'(mem_en), 32'h0);
    chk("rw_mem_addr", 32'(mem_addr), 32'h0);
    chk("rw_mem_wdata", mem_wdata, 32'h0);
    chk("rw_d_rdata", d_rdata, 32'h0);
    chk("rw_if_rdata", if_rdata, 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Simultaneous requests: data first, fetch one full period later
    if_addr = 32'h0000_0020; d_addr = 32'h0000_0044; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    tick();
    chk("tie_first_addr", 32'(mem_addr), 32'h11);
    chk("tie_stall", 32'(stall), 32'h1);
    tick(); tick();
    chk("tie_d_ack", 32'(d_ack), 32'h1);
    chk("tie_stall_ack", 32'(stall), 32'h1);
    d_req = 1'b0;
    tick();
    chk("tie_idle_en", 32'(mem_en), 32'h0);
    chk("tie_idle_stall", 32'(stall), 32'h1);
    tick();
    chk("tie_f_en", 32'(mem_en), 32'h1);
    chk("tie_f_addr", 32'(mem_addr), 32'h8);
    tick(); tick();
    chk("tie_if_ack", 32'(if_ack), 32'h1);
    chk("tie_if_rdata", if_rdata, pat(8));
    if_req = 1'b0;
    tick();

`ifdef ARB_RR_EN
    // Both ports requesting continuously: grants alternate
    if_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      guard = 0;
      while (mem_en !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      chk("rr_en", 32'(mem_en), 32'h1);
      chk("rr_grant", 32'(mem_addr), (g % 2 == 0) ? 32'h80 : 32'h40);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) tick();
`endif

    // Long latency instance: single load
    x_d_addr = 32'h0000_000C; x_d_we = 1'b0; x_d_req = 1'b1;
    tick();
    n = 0; busy_n = 0;
    while (x_d_ack !== 1'b1 && n < 40) begin
      if (x_busy === 1'b1) busy_n++;
      n++;
      tick();
    end
    if (x_busy === 1'b1) busy_n++;
    chk("lat15_ack", 32'(n + 1), 32'd17);
    chk("lat15_busy", 32'(busy_n), 32'd17);
    chk("lat15_rdata", x_d_rdata, pat(3));
    x_d_req = 1'b0;
    tick();
    chk("lat15_idle", 32'(x_busy), 32'h0);

    // Randomized traffic from two protocol-correct requesters
    for (int i = 0; i < 600; i++) begin
      af = (cyc == ack_cyc) && !own_d;
      ad = (cyc == ack_cyc) && own_d;
      if (if_req ? af : ($urandom_range(0, 3) == 0)) begin
        if (if_req && $urandom_range(0, 1) == 0) if_req = 1'b0;
        else begin
          if_req  = 1'b1;
          if_addr = 32'($urandom_range(0, 1023));
        end
      end
      if (d_req ? ad : ($urandom_range(0, 3) == 0)) begin
        if (d_req && $urandom_range(0, 1) == 0) d_req = 1'b0;
        else begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = 32'($urandom_range(0, 1023));
          d_wdata = $urandom();
        end
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (L + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
